// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package rr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } rr_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational priority encoder that scans req upward from ptr, wrapping N-1 -> 0.
module rr_priority_pick
  import rr_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  int p;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    p      = 0;
    for (int i = 0; i < N; i++) begin
      p = (int'(ptr) + i) % N;
      if (!valid && req[p]) begin
        valid     = 1'b1;
        idx       = IW'(p);
        onehot[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Tenure-based round-robin scheduler: holds a one-hot grant until done, go drop
// or hold expiry, then spends one RELEASE cycle before re-arbitrating.
module rr_grant_scheduler
  import rr_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8,
  parameter int IW       = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  go,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  get,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  rr_state_t     state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]  get_q, get_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;

  rr_priority_pick #(.N(N), .IW(IW)) u_pick (
    .req    (go),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    get_d      = get_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      GRANT: begin
        // done wins over a simultaneous hold expiry, so timeout stays low there
        if (done[grant_id_q] || !go[grant_id_q] ||
            hold_cnt_q == HW'(MAX_HOLD - 1)) begin
          state_d   = RELEASE;
          timeout_d = !(done[grant_id_q] || !go[grant_id_q]);
          ptr_d     = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;
          get_d     = '0;
          busy_d    = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        if (pick_valid) begin
          state_d    = GRANT;
          get_d      = pick_onehot;
          grant_id_d = pick_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
          get_d   = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      get_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      get_q      <= get_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign get      = get_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Vector-table bench for rr_grant_scheduler (N=3, MAX_HOLD=4) with an expected-value queue.
module tb_rr_grant_scheduler;

  logic       clk, rst_n;
  logic [2:0] go, done, get;
  logic [1:0] grant_id;
  logic       busy, timeout;

  int checks = 0;
  int errors = 0;

  rr_grant_scheduler #(.N(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .done(done),
    .get(get), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] go, done, get;
    logic       busy, tmo;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic [2:0] g, logic [2:0] d, logic [2:0] eg,
                              logic eb, logic et, logic [1:0] ei);
    vec_t v;
    v.go = g; v.done = d; v.get = eg; v.busy = eb; v.tmo = et; v.id = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, n, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int n);
    vec_t e;
    go   = v.go;
    done = v.done;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("get", n, 32'(get), 32'(e.get));
    chk("busy", n, 32'(busy), 32'(e.busy));
    chk("timeout", n, 32'(timeout), 32'(e.tmo));
    if (e.busy) chk("grant_id", n, 32'(grant_id), 32'(e.id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst_n = 0; go = 3'b111; done = 3'b000;

    // fairness with done pulses, then ignored non-owner done and done at hold expiry
    vecs.push_back(mk(3'b111, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b111, 3'b001, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b010, 1, 0, 1));
    vecs.push_back(mk(3'b111, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b100, 1, 0, 2));
    vecs.push_back(mk(3'b111, 3'b100, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b111, 3'b100, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b111, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b111, 3'b001, 3'b000, 0, 0, 0));
    // hold expiry on owner 1, then re-grant
    vecs.push_back(mk(3'b010, 3'b000, 3'b010, 1, 0, 1));
    vecs.push_back(mk(3'b010, 3'b000, 3'b010, 1, 0, 1));
    vecs.push_back(mk(3'b010, 3'b000, 3'b010, 1, 0, 1));
    vecs.push_back(mk(3'b010, 3'b000, 3'b010, 1, 0, 1));
    vecs.push_back(mk(3'b010, 3'b000, 3'b000, 0, 1, 0));
    vecs.push_back(mk(3'b010, 3'b000, 3'b010, 1, 0, 1));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 0, 0, 0));
    // pointer honoured after release
    vecs.push_back(mk(3'b100, 3'b000, 3'b100, 1, 0, 2));
    vecs.push_back(mk(3'b101, 3'b100, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b101, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b101, 3'b001, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b101, 3'b000, 3'b100, 1, 0, 2));
    // owner 0 drops go mid-grant, then done while idle is ignored
    vecs.push_back(mk(3'b101, 3'b100, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b001, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b001, 3'b000, 3'b001, 1, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b000, 3'b111, 3'b000, 0, 0, 0));
    vecs.push_back(mk(3'b010, 3'b000, 3'b010, 1, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_get", 0, 32'(get), 32'h0);
    chk("rst_busy", 0, 32'(busy), 32'h0);
    chk("rst_timeout", 0, 32'(timeout), 32'h0);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i + 1);

    // asynchronous reset while owner 1 holds the grant
    rst_n = 0;
    #1;
    chk("async_rst_get", 100, 32'(get), 32'h0);
    chk("async_rst_busy", 100, 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(mk(3'b011, 3'b000, 3'b001, 1, 0, 0), 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
